// File: rtl/aes_pkg.sv
// Shared AES types, FSM states and GF(2^8) helpers for the MixColumns datapath.
// Pure declarations; no latency and no flow control of its own.
// Used by mix_single_column and mix_columns_seq.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         NCOL     = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a 4-bit constant as a sum of x, 2x, 4x, 8x.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// One-column (Inv)MixColumns mixer; inverse selected by inv when MIX_COLUMNS_INV_EN is defined.
// Purely combinational, zero latency.
// No flow control; the caller sequences columns through it.
module mix_single_column
  import aes_pkg::*;
(
`ifdef MIX_COLUMNS_INV_EN
  input  logic inv,
`endif
  input  col_t col,
  output col_t mixed
);

  // Row-0 coefficients packed {c0,c1,c2,c3}; row i uses them rotated right by i.
  logic [15:0] coefs;

`ifdef MIX_COLUMNS_INV_EN
  assign coefs = inv ? 16'hEBD9 : 16'h2311;
`else
  assign coefs = 16'h2311;
`endif

  always_comb begin
    mixed = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        mixed[31-8*i -: 8] = mixed[31-8*i -: 8] ^
                             gf_mul(col[31-8*j -: 8], coefs[15-4*((j-i+4)%4) -: 4]);
      end
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns, one column per clock; inverse via inv under MIX_COLUMNS_INV_EN.
// Latency: accept at E0, columns written E1..E4, out_valid registered high after E4.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there for back-to-back.
module mix_columns_seq
  import aes_pkg::*;
(
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inv,
`endif
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  fsm_t       st;
  logic [1:0] col_cnt;
  state_t     work;
  state_t     next_work;
  col_t       cur_col;
  col_t       mixed;
  logic       inv_q;

`ifdef MIX_COLUMNS_INV_EN
  logic inv_d;
  assign inv_d = inv;
`else
  logic inv_d;
  assign inv_d = 1'b0;
`endif

  mix_single_column u_mix (
`ifdef MIX_COLUMNS_INV_EN
    .inv   (inv_q),
`endif
    .col   (cur_col),
    .mixed (mixed)
  );

  always_comb begin
    cur_col   = work[127:96];
    next_work = work;
    case (col_cnt)
      2'd0: begin cur_col = work[127:96]; next_work[127:96] = mixed; end
      2'd1: begin cur_col = work[95:64];  next_work[95:64]  = mixed; end
      2'd2: begin cur_col = work[63:32];  next_work[63:32]  = mixed; end
      default: begin cur_col = work[31:0]; next_work[31:0] = mixed; end
    endcase
  end

  assign in_ready = (st == IDLE) || ((st == DONE) && out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      col_cnt   <= 2'd0;
      work      <= '0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            work    <= in_data;
            inv_q   <= inv_d;
            col_cnt <= 2'd0;
            st      <= BUSY;
          end
        end
        BUSY: begin
          work    <= next_work;
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == 2'(NCOL - 1)) begin
            st        <= DONE;
            out_valid <= 1'b1;
            out_data  <= next_work;
          end
        end
        DONE: begin
          // in_valid is only honoured on the same edge the result drains.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work    <= in_data;
              inv_q   <= inv_d;
              col_cnt <= 2'd0;
              st      <= BUSY;
            end else begin
              st <= IDLE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // inv_q is only consumed by the mixer when the inverse option is built in.
`ifndef MIX_COLUMNS_INV_EN
  logic unused_inv;
  assign unused_inv = inv_q;
`endif

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed self-checking bench for mix_columns_seq: reset, FIPS vectors, backpressure,
// and (with MIX_COLUMNS_INV_EN) inverse vector plus random forward/inverse round trips.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef MIX_COLUMNS_INV_EN
  logic         inv;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mix_columns_seq dut (
`ifdef MIX_COLUMNS_INV_EN
    .inv       (inv),
`endif
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge after E4 with the sampled result.
  task automatic run_op(input string tag, input logic [127:0] din, input logic inv_v,
                        output logic [127:0] res);
    logic seen;
`ifdef MIX_COLUMNS_INV_EN
    inv = inv_v;
`else
    if (inv_v) $display("inverse requested without MIX_COLUMNS_INV_EN");
`endif
    check({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_data  = din;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rnd128();
`ifdef MIX_COLUMNS_INV_EN
    inv = ~inv_v;
`endif
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check({tag, "_early_valid"}, {127'd0, seen}, 128'd0);
    @(negedge clk);
    check({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    res = out_data;
  endtask

  initial begin
    logic [127:0] res, fwd, orig;
    logic         seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
    inv = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);

    run_op("fips", V1_IN, 1'b0, res);
    check("fips_data", res, V1_OUT);
    run_op("vec2", V2_IN, 1'b0, res);
    check("vec2_data", res, V2_OUT);

    // Reset while BUSY: the in-flight state must vanish.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = V2_IN;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    check("midrst_out_data", out_data, 128'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("midrst_no_valid", {127'd0, seen}, 128'd0);

    // Backpressure with ignored in_valid pulses, then back-to-back accept.
    out_ready = 1'b0;
    run_op("bp", V1_IN, 1'b0, res);
    check("bp_data", res, V1_OUT);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = rnd128();
      @(negedge clk);
      check("bp_hold_data", out_data, V1_OUT);
      check("bp_hold_valid", {127'd0, out_valid}, 128'd1);
      check("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    run_op("b2b", V2_IN, 1'b0, res);
    check("b2b_data", res, V2_OUT);

`ifdef MIX_COLUMNS_INV_EN
    run_op("inv", V1_OUT, 1'b1, res);
    check("inv_data", res, V1_IN);
    for (int i = 0; i < 1000; i++) begin
      orig = rnd128();
      run_op("rt_fwd", orig, 1'b0, fwd);
      run_op("rt_inv", fwd, 1'b1, res);
      check("roundtrip", res, orig);
    end
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
